dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port (stack/data/heap/serial address space) between two requesters.
  - Port A: the CPU MEM stage, single-word accesses.
  - Port B: the boot/DMA loader, word bursts with auto-incrementing address.
- Issues at most one memory access per cycle, registers read data back to the winner, and stalls the loser.
- Sits between the pipeline's EX/MEM register and data_memory.

Parameters:
- LEN_W, 8, width of the burst length field; maximum burst is 2^LEN_W-1 beats.
- MAX_A_STREAK, 4, consecutive A grants allowed while a B burst is pending; used only with the guard feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- a_req  in  1  CPU access request, held until a_ack.
- a_we  in  1  CPU write (1) or read (0).
- a_addr  in  32  CPU byte address.
- a_wdata  in  32  CPU write data.
- a_size  in  2  access size, passed through unchanged.
- a_ack  out  1  CPU access performed this cycle; combinational.
- a_stall  out  1  = a_req & ~a_ack.
- a_rdata  out  32  registered CPU read data.
- a_rvalid  out  1  a_rdata valid, one-cycle pulse.
- b_start  in  1  start a burst; sampled only when b_busy=0.
- b_we  in  1  burst direction.
- b_addr  in  32  burst start address; must be word-aligned.
- b_len  in  LEN_W  burst length in beats; 0 means no-op.
- b_wdata  in  32  write data for the current beat.
- b_ack  out  1  B beat performed this cycle.
- b_rdata  out  32  registered B read data.
- b_rvalid  out  1  b_rdata valid, one-cycle pulse.
- b_busy  out  1  burst in progress.
- b_done  out  1  one-cycle pulse after the last beat.
- mem_addr  out  32  to data_memory.
- mem_wdata  out  32  to data_memory.
- mem_size  out  2  to data_memory.
- mem_re  out  1  to data_memory.
- mem_we  out  1  to data_memory.
- mem_rdata  in  32  from data_memory; asynchronous read.

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE; all outputs, address and beat counters, and the streak counter are 0.
  - Reset mid-burst abandons the burst; no b_done is issued.
- FSM states and transitions:
  - IDLE -> BURST on b_start with b_len!=0. Latch cur_addr=b_addr, beats_left=b_len, dir=b_we. b_busy=1 from the next cycle.
  - b_start with b_len=0: b_done pulses next cycle; FSM stays in IDLE.
  - BURST -> DONE when the last beat is acked (beats_left==1 & b_ack).
  - DONE -> IDLE after one cycle; b_done=1 during DONE; b_busy=0 in DONE.
- Grant, evaluated combinationally each cycle:
  - a_req=1: A wins. a_ack=1; mem_* driven from a_*.
  - Else, in BURST: a B beat is issued. b_ack=1; mem_addr=cur_addr; mem_we=dir; mem_wdata=b_wdata; mem_size=2'b11.
  - Otherwise mem_re=mem_we=0 and mem_addr=0.
  - mem_re = granted & ~we.
- Per B beat: cur_addr += 4 (32-bit wrap, no error); beats_left -= 1.
- Read return:
  - Read granted in cycle k: mem_rdata is captured at the edge ending cycle k.
  - *_rdata and *_rvalid=1 appear in cycle k+1.
  - *_rdata holds its value until the next read.
- Writes commit at the edge ending the grant cycle.
- Back-to-back A reads are acked every cycle; each gets rvalid one cycle later.
- A and B never both ack in the same cycle.
- Simultaneous b_start and a_req in IDLE: the burst is latched; A is served first.

Optional Feature:
- Macro: DMEM_ARB_STARVE_GUARD_EN.
- When defined:
  - A saturating streak counter increments on each A grant while in BURST.
  - When streak==MAX_A_STREAK, the next cycle grants B regardless of a_req; a_stall=1 that cycle.
  - The streak clears on any B grant or on leaving BURST.
- When undefined: strict A priority; B may starve indefinitely; no counter is synthesized.

Decomposition:
- Shared package dmem_arb_pkg:
  - FSM state encoding (IDLE/BURST/DONE).
  - WORD_BYTES=4.
  - SIZE_WORD=2'b11.
- One natural sub-module, dmem_burst_ctr: holds cur_addr and beats_left, with load, step and last outputs.
- The grant logic and return registers stay in the top module.

Test Plan:
- A read only: a_req=1, a_addr=0x10010004, memory word=0xDEADBEEF -> a_ack in the same cycle; a_rvalid=1 and a_rdata=0xDEADBEEF next cycle; b_ack=0.
- B write burst: b_start, b_addr=0x10040000, b_len=3, a_req=0 -> b_ack for 3 consecutive cycles at 0x10040000/04/08; b_done one cycle after the third beat; b_busy low again.
- Contention: B burst len=2 in progress and a_req held 2 cycles -> A acked both cycles; B beats resume afterwards; final address 0x..04; exactly 2 b_ack pulses total.
- Guard (macro on, MAX_A_STREAK=4): a_req held continuously during a burst -> after 4 A grants, one b_ack with a_stall=1; the pattern repeats until the burst completes.
- Reset mid-burst: reset=0 after beat 1 of len=5 -> next cycle b_busy=0, mem_we=0, no b_done; a new b_start is accepted normally.
- Edge cases:
  - b_len=0 -> no b_ack; b_done one cycle later.
  - Burst from 0xFFFFFFFC, len=2 -> second beat at 0x00000000.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter slice.
//   arb_state_e : burst FSM state encoding (IDLE / BURST / DONE)
//   WORD_BYTES  : address increment per burst beat
//   SIZE_WORD   : mem_size code used for every burst beat
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [1:0]  SIZE_WORD  = 2'b11;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the CPU port (a_*), the loader burst port (b_*)
// and the data_memory port (mem_*).
//   modport slave  : seen by dmem_arbiter
//   modport master : seen by the requesters and the memory model around it
// Parameter LEN_W sets the width of b_len.
interface dmem_arbiter_if #(parameter int LEN_W = 8);

  // CPU (MEM stage) port
  logic              a_req;
  logic              a_we;
  logic [31:0]       a_addr;
  logic [31:0]       a_wdata;
  logic [1:0]        a_size;
  logic              a_ack;
  logic              a_stall;
  logic [31:0]       a_rdata;
  logic              a_rvalid;

  // Boot/DMA loader burst port
  logic              b_start;
  logic              b_we;
  logic [31:0]       b_addr;
  logic [LEN_W-1:0]  b_len;
  logic [31:0]       b_wdata;
  logic              b_ack;
  logic [31:0]       b_rdata;
  logic              b_rvalid;
  logic              b_busy;
  logic              b_done;

  // data_memory port
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        mem_size;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_size,
    output a_ack, a_stall, a_rdata, a_rvalid,
    input  b_start, b_we, b_addr, b_len, b_wdata,
    output b_ack, b_rdata, b_rvalid, b_busy, b_done,
    output mem_addr, mem_wdata, mem_size, mem_re, mem_we,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, a_size,
    input  a_ack, a_stall, a_rdata, a_rvalid,
    output b_start, b_we, b_addr, b_len, b_wdata,
    input  b_ack, b_rdata, b_rvalid, b_busy, b_done,
    input  mem_addr, mem_wdata, mem_size, mem_re, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_burst_ctr.sv
// dmem_burst_ctr: address and beat bookkeeping for one loader burst.
//   clock, reset     : clock and synchronous active-low reset
//   load             : capture load_addr / load_len (burst start)
//   step             : one beat performed; advance address by a word, count down
//   cur_addr         : address of the next beat (wraps at 32 bits)
//   beats_left       : beats still to perform
//   last             : the next beat is the final one
module dmem_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [31:0]      load_addr,
  input  logic [LEN_W-1:0] load_len,
  input  logic             step,
  output logic [31:0]      cur_addr,
  output logic [LEN_W-1:0] beats_left,
  output logic             last
);

  logic [31:0]      addr_r;
  logic [LEN_W-1:0] left_r;

  // Address / remaining-beat registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_r <= 32'd0;
      left_r <= {LEN_W{1'b0}};
    end else if (load) begin
      addr_r <= load_addr;
      left_r <= load_len;
    end else if (step) begin
      addr_r <= addr_r + 32'(WORD_BYTES);
      left_r <= left_r - {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      addr_r <= addr_r;
      left_r <= left_r;
    end
  end

  assign cur_addr   = addr_r;
  assign beats_left = left_r;
  assign last       = (left_r == {{(LEN_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage
// (port A, single words, strict priority) and the boot/DMA loader (port B,
// auto-incrementing word bursts). At most one access per cycle; read data is
// registered back to the winner one cycle after the grant.
//   clock, reset : clock and synchronous active-low reset
//   bus          : dmem_arbiter_if.slave (a_*, b_*, mem_* signals)
// Optional build macro DMEM_ARB_STARVE_GUARD_EN: after MAX_A_STREAK
// consecutive A grants during a burst, one beat is forced to B.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int LEN_W        = 8,
  parameter int MAX_A_STREAK = 4
) (
  input  logic            clock,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);

  arb_state_e       state_r, state_n;
  logic             dir_r;
  logic             a_grant_s, b_grant_s, guard_force_s;
  logic             load_s, done_set_s, last_s;
  logic [31:0]      cur_addr_s;
  logic [LEN_W-1:0] beats_left_s;
  logic             b_done_r;
  logic [31:0]      a_rdata_r, b_rdata_r;
  logic             a_rvalid_r, b_rvalid_r;

  dmem_burst_ctr #(.LEN_W(LEN_W)) u_ctr (
    .clock      (clock),
    .reset      (reset),
    .load       (load_s),
    .load_addr  (bus.b_addr),
    .load_len   (bus.b_len),
    .step       (b_grant_s),
    .cur_addr   (cur_addr_s),
    .beats_left (beats_left_s),
    .last       (last_s)
  );

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int STREAK_W = $clog2(MAX_A_STREAK + 1);
  logic [STREAK_W-1:0] streak_r;

  // Consecutive A grants seen while a burst waits; saturates at the limit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      streak_r <= {STREAK_W{1'b0}};
    end else if ((state_r != ST_BURST) || b_grant_s) begin
      streak_r <= {STREAK_W{1'b0}};
    end else if (a_grant_s && (streak_r != STREAK_W'(MAX_A_STREAK))) begin
      streak_r <= streak_r + {{(STREAK_W-1){1'b0}}, 1'b1};
    end else begin
      streak_r <= streak_r;
    end
  end

  assign guard_force_s = (state_r == ST_BURST) && (streak_r == STREAK_W'(MAX_A_STREAK));
`else
  assign guard_force_s = 1'b0;
`endif

  // Grant selection; nothing is issued while reset is held.
  always_comb begin
    a_grant_s = 1'b0;
    b_grant_s = 1'b0;
    if (!reset) begin
      a_grant_s = 1'b0;
    end else if (bus.a_req && !guard_force_s) begin
      a_grant_s = 1'b1;
    end else if (state_r == ST_BURST) begin
      b_grant_s = 1'b1;
    end else begin
      a_grant_s = 1'b0;
    end
  end

  // Memory port mux driven from the granted requester.
  always_comb begin
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_size  = 2'b00;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    if (a_grant_s) begin
      bus.mem_addr  = bus.a_addr;
      bus.mem_wdata = bus.a_wdata;
      bus.mem_size  = bus.a_size;
      bus.mem_we    = bus.a_we;
      bus.mem_re    = ~bus.a_we;
    end else if (b_grant_s) begin
      bus.mem_addr  = cur_addr_s;
      bus.mem_wdata = bus.b_wdata;
      bus.mem_size  = SIZE_WORD;
      bus.mem_we    = dir_r;
      bus.mem_re    = ~dir_r;
    end else begin
      bus.mem_we    = 1'b0;
    end
  end

  // Burst FSM next state; a zero-length start only produces b_done.
  always_comb begin
    state_n    = state_r;
    load_s     = 1'b0;
    done_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.b_start && (bus.b_len != {LEN_W{1'b0}})) begin
          state_n = ST_BURST;
          load_s  = 1'b1;
        end else begin
          state_n    = ST_IDLE;
          done_set_s = bus.b_start;
        end
      end
      ST_BURST: begin
        if (b_grant_s && last_s) begin
          state_n    = ST_DONE;
          done_set_s = 1'b1;
        end else begin
          state_n = ST_BURST;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, burst direction, done pulse and read-return registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      dir_r      <= 1'b0;
      b_done_r   <= 1'b0;
      a_rdata_r  <= 32'd0;
      a_rvalid_r <= 1'b0;
      b_rdata_r  <= 32'd0;
      b_rvalid_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      dir_r      <= load_s ? bus.b_we : dir_r;
      b_done_r   <= done_set_s;
      a_rvalid_r <= a_grant_s & ~bus.a_we;
      a_rdata_r  <= (a_grant_s & ~bus.a_we) ? bus.mem_rdata : a_rdata_r;
      b_rvalid_r <= b_grant_s & ~dir_r;
      b_rdata_r  <= (b_grant_s & ~dir_r) ? bus.mem_rdata : b_rdata_r;
    end
  end

  assign bus.a_ack    = a_grant_s;
  assign bus.a_stall  = bus.a_req & ~a_grant_s;
  assign bus.a_rdata  = a_rdata_r;
  assign bus.a_rvalid = a_rvalid_r;
  assign bus.b_ack    = b_grant_s;
  assign bus.b_rdata  = b_rdata_r;
  assign bus.b_rvalid = b_rvalid_r;
  assign bus.b_busy   = (state_r == ST_BURST);
  assign bus.b_done   = b_done_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized + directed bench for dmem_arbiter.
// A reference model samples every cycle and predicts grants, memory-port
// values and burst status from the arbitration rules; predicted read data is
// queued and a separate monitor pops it whenever a *_rvalid appears.
// Build with +define+DMEM_ARB_STARVE_GUARD_EN to exercise the starvation guard.
module tb_dmem_arbiter;
  localparam int LEN_W        = 8;
  localparam int MAX_A_STREAK = 4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.LEN_W(LEN_W)) bus();
  dmem_arbiter #(.LEN_W(LEN_W), .MAX_A_STREAK(MAX_A_STREAK)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory behind the arbiter: 64 words, aliased on addr[7:2].
  logic [31:0] dmem    [0:63];
  bit          written [0:63];
  function automatic logic [31:0] init_val(input logic [5:0] i);
    return (i == 6'd1) ? 32'hDEADBEEF : (32'hA5A50000 | {26'd0, i});
  endfunction
  assign bus.mem_rdata = written[bus.mem_addr[7:2]] ? dmem[bus.mem_addr[7:2]]
                                                    : init_val(bus.mem_addr[7:2]);
  always @(posedge clock) begin
    if (bus.mem_we) begin
      dmem[bus.mem_addr[7:2]]    <= bus.mem_wdata;
      written[bus.mem_addr[7:2]] <= 1'b1;
    end
  end

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  typedef struct { logic [31:0] data; int due; } rd_t;
  rd_t a_q[$];
  rd_t b_q[$];

  // Reference model state
  logic [31:0] ref_mem [0:63];
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  bit          m_dir  = 1'b0;
  logic [31:0] m_addr = 32'd0;
  int          m_left = 0;
  int          m_streak = 0;

  task automatic model_cycle();
    bit ea, eb, force_b, busy0, done_set;
    force_b = GUARD && m_busy && (m_streak == MAX_A_STREAK);
    ea = reset && bus.a_req && !force_b;
    eb = reset && m_busy && !ea;
    chk("a_ack",   bus.a_ack,   ea);
    chk("b_ack",   bus.b_ack,   eb);
    chk("a_stall", bus.a_stall, bus.a_req && !ea);
    chk("b_busy",  bus.b_busy,  m_busy);
    chk("b_done",  bus.b_done,  m_done);
    if (ea) begin
      chk("a_mem_addr", bus.mem_addr, bus.a_addr);
      chk("a_mem_we",   bus.mem_we,   bus.a_we);
      chk("a_mem_re",   bus.mem_re,   !bus.a_we);
      chk("a_mem_size", bus.mem_size, bus.a_size);
      if (bus.a_we) begin
        chk("a_mem_wdata", bus.mem_wdata, bus.a_wdata);
        ref_mem[bus.a_addr[7:2]] = bus.a_wdata;
      end else begin
        a_q.push_back('{ref_mem[bus.a_addr[7:2]], cyc + 1});
      end
    end else if (eb) begin
      chk("b_mem_addr", bus.mem_addr, m_addr);
      chk("b_mem_we",   bus.mem_we,   m_dir);
      chk("b_mem_re",   bus.mem_re,   !m_dir);
      chk("b_mem_size", bus.mem_size, 2'b11);
      if (m_dir) begin
        chk("b_mem_wdata", bus.mem_wdata, bus.b_wdata);
        ref_mem[m_addr[7:2]] = bus.b_wdata;
      end else begin
        b_q.push_back('{ref_mem[m_addr[7:2]], cyc + 1});
      end
      m_addr = m_addr + 32'd4;
      m_left = m_left - 1;
    end else begin
      chk("idle_mem_we",   bus.mem_we,   1'b0);
      chk("idle_mem_re",   bus.mem_re,   1'b0);
      chk("idle_mem_addr", bus.mem_addr, 32'd0);
    end
    if (!reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_streak = 0;
      return;
    end
    busy0 = m_busy;
    done_set = 1'b0;
    if (!busy0 || eb) m_streak = 0;
    else if (ea && m_streak < MAX_A_STREAK) m_streak++;
    if (eb && m_left == 0) begin
      m_busy = 1'b0;
      done_set = 1'b1;
    end
    if (!busy0 && !m_done && bus.b_start) begin
      if (bus.b_len != '0) begin
        m_busy = 1'b1;
        m_addr = bus.b_addr;
        m_left = int'(bus.b_len);
        m_dir  = bus.b_we;
      end else begin
        done_set = 1'b1;
      end
    end
    m_done = done_set;
  endtask

  // Model/predictor: runs on every falling edge.
  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i[5:0]);
    forever begin
      @(negedge clock);
      model_cycle();
      cyc++;
    end
  end

  // Monitor: pops the scoreboard whenever read data is presented.
  logic [31:0] a_hold = 32'd0;
  logic [31:0] b_hold = 32'd0;
  task automatic mon();
    int now = cyc - 1;
    rd_t e;
    if (bus.a_rvalid) begin
      if (a_q.size() == 0) chk("a_rvalid_spurious", bus.a_rvalid, 1'b0);
      else begin
        e = a_q.pop_front();
        chk("a_rdata", bus.a_rdata, e.data);
        chk("a_rvalid_cycle", now, e.due);
        a_hold = e.data;
      end
    end else begin
      chk("a_rdata_hold", bus.a_rdata, a_hold);
      if (a_q.size() != 0 && a_q[0].due <= now) begin
        void'(a_q.pop_front());
        chk("a_rvalid_missing", bus.a_rvalid, 1'b1);
      end
    end
    if (bus.b_rvalid) begin
      if (b_q.size() == 0) chk("b_rvalid_spurious", bus.b_rvalid, 1'b0);
      else begin
        e = b_q.pop_front();
        chk("b_rdata", bus.b_rdata, e.data);
        chk("b_rvalid_cycle", now, e.due);
        b_hold = e.data;
      end
    end else begin
      chk("b_rdata_hold", bus.b_rdata, b_hold);
      if (b_q.size() != 0 && b_q[0].due <= now) begin
        void'(b_q.pop_front());
        chk("b_rvalid_missing", bus.b_rvalid, 1'b1);
      end
    end
    if (!reset) begin
      a_hold = 32'd0;
      b_hold = 32'd0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #2;
      mon();
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
    bus.b_wdata = $urandom;
  endtask

  task automatic a_access(input bit we, input logic [31:0] addr, input logic [31:0] data);
    bit got = 1'b0;
    bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data; bus.a_size = 2'b11;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      got = bus.a_ack;
      step();
      if (got) break;
    end
    bus.a_req = 1'b0;
    if (!got) chk("a_ack_timeout", got, 1'b1);
  endtask

  task automatic b_kick(input bit we, input logic [31:0] addr, input int len);
    bus.b_start = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_len = LEN_W'(len);
    step();
    bus.b_start = 1'b0;
  endtask

  task automatic wait_b_done();
    bit got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (bus.b_done) begin got = 1'b1; break; end
    end
    step();
    if (!got) chk("b_done_timeout", got, 1'b1);
  endtask

  initial begin
    bit aa, busy, dn;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 32'd0; bus.a_wdata = 32'd0; bus.a_size = 2'b00;
    bus.b_start = 1'b0; bus.b_we = 1'b0; bus.b_addr = 32'd0; bus.b_len = '0; bus.b_wdata = 32'd0;
    reset = 1'b0;
    repeat (3) step();
    chk("rst_a_rdata", bus.a_rdata, 32'd0);
    chk("rst_b_busy", bus.b_busy, 1'b0);
    reset = 1'b1;
    step();

    a_access(1'b0, 32'h10010004, 32'd0);            // read of preset 0xDEADBEEF
    step();
    b_kick(1'b1, 32'h10040000, 3);                   // plain write burst
    wait_b_done();
    b_kick(1'b0, 32'h10010010, 2);                   // contention: A during a burst
    a_access(1'b1, 32'h10010014, 32'h12345678);
    a_access(1'b0, 32'h10010018, 32'd0);
    wait_b_done();
    b_kick(1'b1, 32'h10010020, 6);                   // A held continuously
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_size = 2'b10;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      aa = bus.a_ack;
      step();
      if (aa) begin
        bus.a_we = $urandom_range(0, 1) != 0;
        bus.a_addr = 32'h10010000 | (32'($urandom_range(0, 15)) << 2);
        bus.a_wdata = $urandom;
      end
    end
    bus.a_req = 1'b0;
    wait_b_done();
    b_kick(1'b1, 32'h10010000, 5);                   // reset after the first beat
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    b_kick(1'b0, 32'h10010000, 2);
    wait_b_done();
    b_kick(1'b0, 32'h10010000, 0);                   // zero-length burst
    step(); step();
    b_kick(1'b1, 32'hFFFFFFFC, 2);                   // address wrap
    wait_b_done();
    b_kick(1'b0, 32'hFFFFFFFC, 2);
    wait_b_done();

    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      aa = bus.a_ack; busy = bus.b_busy; dn = bus.b_done;
      step();
      reset = ($urandom_range(0, 299) != 0);
      if (!bus.a_req || aa) begin
        bus.a_req   = $urandom_range(0, 2) != 0;
        bus.a_we    = $urandom_range(0, 1) != 0;
        bus.a_addr  = 32'h10010000 | (32'($urandom_range(0, 15)) << 2);
        bus.a_wdata = $urandom;
        bus.a_size  = 2'($urandom_range(0, 3));
      end
      if (bus.b_start) bus.b_start = 1'b0;
      else if (!busy && !dn && $urandom_range(0, 5) == 0) begin
        bus.b_start = 1'b1;
        bus.b_we    = $urandom_range(0, 1) != 0;
        bus.b_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8
                    : (32'h10010000 | (32'($urandom_range(0, 15)) << 2));
        bus.b_len   = LEN_W'($urandom_range(0, 9));
      end
    end
    reset = 1'b1;
    bus.a_req = 1'b0;
    bus.b_start = 1'b0;
    repeat (60) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
